hit_scheduler: RTL and testbench

HIT_SCHEDULER -- requirements
Module: hit_scheduler

---
 rtl/hit_scheduler.sv | 148 ++++++++++++++
 tb/tb_hit_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_scheduler.sv
// Per-ray closest-hit scheduler: issues one triangle test per cycle and
// reduces in-order datapath results to the nearest positive hit.
module hit_scheduler #(
  parameter int Q_BITS   = 10,
  parameter int IDX_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ray_fifo_empty,
  output logic                 ray_fifo_rd_en,
  input  logic [191:0]         ray_fifo_dout,
  input  logic [IDX_BITS:0]    num_tris,
  output logic [95:0]          ray_org,
  output logic [95:0]          ray_dir,
  output logic                 tri_valid,
  output logic [IDX_BITS-1:0]  tri_idx,
  input  logic                 res_valid,
  input  logic                 res_hit,
  input  logic signed [31:0]   res_t,
  input  logic                 out_fifo_full,
  output logic                 out_fifo_wr_en,
  output logic [IDX_BITS+32:0] out_fifo_din
);

  localparam logic signed [31:0] TMax = 32'sh7FFF_FFFF;

  if (Q_BITS < 0 || Q_BITS > 31) begin : g_bad_q
    $error("Q_BITS must fit inside a 32-bit word");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_WRITE
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_BITS:0]     issue_q, issue_d;
  logic [IDX_BITS:0]     ret_q, ret_d;
  logic [IDX_BITS:0]     ntris_q, ntris_d;
  logic                  hit_q, hit_d;
  logic [IDX_BITS-1:0]   bidx_q, bidx_d;
  logic signed [31:0]    bt_q, bt_d;
  logic [95:0]           org_q, org_d;
  logic [95:0]           dir_q, dir_d;
  logic                  hold_q;
  logic                  rd_c, tv_c, wr_c;
  logic                  res_ok;

  assign res_ok = res_valid && res_hit
                  && (res_t > 32'sd0) && (res_t < bt_q);

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    ret_d   = ret_q;
    ntris_d = ntris_q;
    hit_d   = hit_q;
    bidx_d  = bidx_q;
    bt_d    = bt_q;
    org_d   = org_q;
    dir_d   = dir_q;
    rd_c    = 1'b0;
    tv_c    = 1'b0;
    wr_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!ray_fifo_empty && !hold_q) begin
          rd_c    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        org_d   = ray_fifo_dout[95:0];
        dir_d   = ray_fifo_dout[191:96];
        ntris_d = num_tris;
        issue_d = '0;
        ret_d   = '0;
        hit_d   = 1'b0;
        bidx_d  = '0;
        bt_d    = TMax;
        state_d = (num_tris == '0) ? S_WRITE : S_ISSUE;
      end
      S_ISSUE: begin
        tv_c    = 1'b1;
        issue_d = issue_q + 1'b1;
        if (issue_q == ntris_q - 1'b1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (ret_q == ntris_q) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!out_fifo_full) begin
          wr_c    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Results only belong to the ray while it is issuing or draining.
    if (res_valid && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
      ret_d = ret_q + 1'b1;
      if (res_ok) begin
        bt_d   = res_t;
        bidx_d = ret_q[IDX_BITS-1:0];
        hit_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      ret_q   <= '0;
      ntris_q <= '0;
      hit_q   <= 1'b0;
      bidx_q  <= '0;
      bt_q    <= TMax;
      org_q   <= '0;
      dir_q   <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      ntris_q <= ntris_d;
      hit_q   <= hit_d;
      bidx_q  <= bidx_d;
      bt_q    <= bt_d;
      org_q   <= org_d;
      dir_q   <= dir_d;
      hold_q  <= 1'b0;
    end
  end

  // Strobes are masked while reset is high, whatever state is held.
  assign ray_fifo_rd_en = rd_c && !reset;
  assign tri_valid      = tv_c && !reset;
  assign out_fifo_wr_en = wr_c && !reset;
  assign tri_idx        = issue_q[IDX_BITS-1:0];
  assign ray_org        = org_q;
  assign ray_dir        = dir_q;
  assign out_fifo_din   = {hit_q, bidx_q, bt_q};

endmodule

// File: tb/tb_hit_scheduler.sv
// Scoreboard bench for hit_scheduler: ray FIFO, datapath and output
// FIFO models driven by randomized stimulus and a closest-hit model.
module tb_hit_scheduler;
  localparam int IB = 8;
  localparam int OW = IB + 33;
  localparam logic [31:0] TMAX = 32'h7FFF_FFFF;

  typedef logic [191:0] w_t;
  typedef logic [IB:0]  nt_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          ray_fifo_empty, ray_fifo_rd_en;
  logic [191:0]  ray_fifo_dout;
  logic [IB:0]   num_tris;
  logic [95:0]   ray_org, ray_dir;
  logic          tri_valid;
  logic [IB-1:0] tri_idx;
  logic          res_valid, res_hit;
  logic [31:0]   res_t;
  logic          out_fifo_full, out_fifo_wr_en;
  logic [OW-1:0] out_fifo_din;

  hit_scheduler #(.Q_BITS(10), .IDX_BITS(IB)) dut (
    .clock(clock), .reset(reset),
    .ray_fifo_empty(ray_fifo_empty), .ray_fifo_rd_en(ray_fifo_rd_en),
    .ray_fifo_dout(ray_fifo_dout), .num_tris(num_tris),
    .ray_org(ray_org), .ray_dir(ray_dir),
    .tri_valid(tri_valid), .tri_idx(tri_idx),
    .res_valid(res_valid), .res_hit(res_hit), .res_t(res_t),
    .out_fifo_full(out_fifo_full), .out_fifo_wr_en(out_fifo_wr_en),
    .out_fifo_din(out_fifo_din)
  );

  always #5 clock = ~clock;

  typedef struct { logic [191:0] w; int nt; int slot; } ray_t;
  typedef struct { logic [OW-1:0] din; logic [191:0] w; int nt; int slot; } exp_t;
  typedef struct { int due; int slot; int idx; } pend_t;

  ray_t  rq[$];
  exp_t  sb[$];
  pend_t pq[$];
  logic        hit_a [16][256];
  logic [31:0] t_a   [16][256];
  int pop_cyc [16];

  int nvec = 0, nmis = 0, cyc = 0, lat = 1, push_n = 0;
  int exp_idx = 0, outstanding = 0, full_hold = 0, cur_slot = 0;
  bit rand_full = 0, in_load = 0, full_seen = 0, last_tv = 0;

  localparam logic [OW-1:0] MISS = {1'b0, {IB{1'b0}}, TMAX};

  task automatic chk(string nm, w_t act, w_t exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int nslot();
    return push_n % 16;
  endfunction

  task automatic set_res(int i, bit h, logic [31:0] t);
    hit_a[nslot()][i] = h;
    t_a[nslot()][i]   = t;
  endtask

  function automatic logic [31:0] rnd_t();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFB;
      2: return 32'h8000_0000;
      3: return TMAX;
      4: return 32'($urandom_range(1, 64));
      5: return 32'($urandom_range(1, 64));
      default: return $urandom;
    endcase
  endfunction

  task automatic fill_rand(int nt);
    for (int i = 0; i < nt; i++) set_res(i, 1'($urandom), rnd_t());
  endtask

  // Closest hit: smallest strictly-positive t below TMAX; first index on ties.
  function automatic logic [OW-1:0] ref_out(int s, int nt);
    int qi[$];
    logic signed [31:0] m;
    int bi;
    for (int i = 0; i < nt; i++)
      if (hit_a[s][i] && $signed(t_a[s][i]) > 0 && $signed(t_a[s][i]) < $signed(TMAX))
        qi.push_back(i);
    if (qi.size() == 0) return MISS;
    m = TMAX;
    foreach (qi[k]) if ($signed(t_a[s][qi[k]]) < m) m = t_a[s][qi[k]];
    bi = -1;
    foreach (qi[k]) if (bi < 0 && t_a[s][qi[k]] == m) bi = qi[k];
    return {1'b1, IB'(bi), m};
  endfunction

  task automatic add_ray(int nt, bit expect_out);
    ray_t r;
    exp_t e;
    r.w    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r.nt   = nt;
    r.slot = nslot();
    if (expect_out) begin
      e.din = ref_out(r.slot, nt);
      e.w = r.w; e.nt = nt; e.slot = r.slot;
      sb.push_back(e);
    end
    rq.push_back(r);
    push_n++;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((sb.size() != 0 || rq.size() != 0 || outstanding != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) begin
      nvec++; nmis++;
      $display("FAIL wait_idle: timeout with %0d writes pending", sb.size());
      sb.delete(); rq.delete();
    end
    repeat (8) @(negedge clock);
  endtask

  // Environment: ray FIFO, fixed-latency datapath, output FIFO, monitor.
  initial begin
    forever begin
      pend_t p;
      ray_t  r;
      exp_t  e;
      @(negedge clock);
      cyc++;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        res_valid = 1'b1;
        res_hit   = hit_a[p.slot][p.idx];
        res_t     = t_a[p.slot][p.idx];
      end else begin
        res_valid = 1'b0;
        res_hit   = 1'($urandom);
        res_t     = $urandom;
      end
      if (full_hold > 0) begin
        out_fifo_full = 1'b1;
        full_hold--;
      end else begin
        out_fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      if (out_fifo_full) full_seen = 1;
      if (in_load) in_load = 0;
      else begin
        num_tris      = nt_t'($urandom);
        ray_fifo_dout = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      #1;
      ray_fifo_empty = (rq.size() == 0);
      #1;
      if (ray_fifo_rd_en) begin
        chk("rd_one_in_flight", w_t'(outstanding), w_t'(0));
        chk("rd_wr_excl", w_t'(out_fifo_wr_en), w_t'(0));
        if (rq.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL rd_when_empty: rd_en=1 want 0");
        end else begin
          r = rq.pop_front();
          ray_fifo_dout = r.w;
          num_tris      = nt_t'(r.nt);
          cur_slot      = r.slot;
          pop_cyc[r.slot] = cyc;
          in_load = 1; exp_idx = 0; outstanding = 1; full_seen = 0;
        end
      end
      if (tri_valid) begin
        chk("tri_idx", w_t'(tri_idx), w_t'(exp_idx));
        chk("tri_consec", w_t'((exp_idx == 0) || last_tv), w_t'(1));
        p.due = cyc + lat; p.slot = cur_slot; p.idx = int'(tri_idx);
        pq.push_back(p);
        exp_idx++;
      end
      last_tv = tri_valid;
      if (out_fifo_wr_en) begin
        chk("wr_when_full", w_t'(out_fifo_full), w_t'(0));
        if (sb.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_write: din=%0h", out_fifo_din);
        end else begin
          e = sb.pop_front();
          chk("out_din", w_t'(out_fifo_din), w_t'(e.din));
          chk("ray_org", w_t'(ray_org), w_t'(e.w[95:0]));
          chk("ray_dir", w_t'(ray_dir), w_t'(e.w[191:96]));
          chk("issued_cnt", w_t'(exp_idx), w_t'(e.nt));
          if (e.nt == 0 && !full_seen)
            chk("zero_tri_lat", w_t'(cyc - pop_cyc[e.slot]), w_t'(2));
        end
        outstanding = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0] d0;
    int n;
    reset = 1'b1; res_valid = 1'b0; res_hit = 1'b0; res_t = '0;
    out_fifo_full = 1'b0; ray_fifo_empty = 1'b1;
    ray_fifo_dout = '0; num_tris = '0;

    // Reset state, with a zero-triangle ray already waiting.
    add_ray(0, 1);
    repeat (3) begin
      @(negedge clock); #3;
      chk("rst_rd_en", w_t'(ray_fifo_rd_en), w_t'(0));
      chk("rst_tri_valid", w_t'(tri_valid), w_t'(0));
      chk("rst_wr_en", w_t'(out_fifo_wr_en), w_t'(0));
      chk("rst_ray_org", w_t'(ray_org), w_t'(0));
      chk("rst_din", w_t'(out_fifo_din), w_t'(MISS));
    end
    @(negedge clock);
    reset = 1'b0;
    #3;
    chk("post_rst_rd_en", w_t'(ray_fifo_rd_en), w_t'(0));
    @(negedge clock); #3;
    chk("rd_after_hold", w_t'(ray_fifo_rd_en), w_t'(1));
    wait_idle(200);

    // Four hits, latency 3, tie on 0x400 keeps the lower index.
    lat = 3;
    set_res(0, 1, 32'h800); set_res(1, 1, 32'h400);
    set_res(2, 1, 32'h600); set_res(3, 1, 32'h400);
    add_ray(4, 1);
    wait_idle(200);

    // Non-positive t, res_hit=0, all-negative, tie, and TMAX itself.
    lat = 2;
    set_res(0, 1, 32'h0); set_res(1, 1, 32'hFFFF_FFFB); set_res(2, 1, 32'h100);
    add_ray(3, 1);
    set_res(0, 0, 32'h50); set_res(1, 0, 32'h20); set_res(2, 1, 32'h100);
    add_ray(3, 1);
    set_res(0, 1, 32'hFFFF_FFFF); set_res(1, 1, 32'hFFFF_FC00);
    set_res(2, 1, 32'h8000_0000);
    add_ray(3, 1);
    set_res(0, 1, 32'h300); set_res(1, 1, 32'h200); set_res(2, 1, 32'h200);
    add_ray(3, 1);
    set_res(0, 1, TMAX);
    add_ray(1, 1);
    wait_idle(400);

    // Output FIFO back-pressure while a second ray waits.
    lat = 1;
    full_hold = 1000;
    fill_rand(2);
    add_ray(2, 1);
    repeat (15) @(negedge clock);
    fill_rand(3);
    add_ray(3, 1);
    #3;
    d0 = out_fifo_din;
    repeat (5) begin
      @(negedge clock); #3;
      chk("full_wr_en", w_t'(out_fifo_wr_en), w_t'(0));
      chk("full_din_stable", w_t'(out_fifo_din), w_t'(d0));
      chk("full_rd_en", w_t'(ray_fifo_rd_en), w_t'(0));
    end
    full_hold = 0;
    wait_idle(400);

    // Reset while issuing index 2 of 8; stale results land in IDLE.
    lat = 4;
    for (int i = 0; i < 8; i++) set_res(i, 1, 32'h10 + 32'(i));
    add_ray(8, 0);
    n = 0;
    do begin
      @(negedge clock); #3;
      n++;
    end while (!(tri_valid && tri_idx == 2) && n < 100);
    if (n >= 100) begin
      nvec++; nmis++;
      $display("FAIL wait_idx2: tri_idx 2 never issued");
    end
    reset = 1'b1;
    @(negedge clock); #3;
    chk("rst_mid_tri_valid", w_t'(tri_valid), w_t'(0));
    chk("rst_mid_ray_org", w_t'(ray_org), w_t'(0));
    chk("rst_mid_din", w_t'(out_fifo_din), w_t'(MISS));
    reset = 1'b0;
    outstanding = 0; exp_idx = 0;
    repeat (12) begin
      @(negedge clock); #3;
      chk("stale_no_wr", w_t'(out_fifo_wr_en), w_t'(0));
    end
    for (int i = 0; i < 5; i++) set_res(i, 1, 32'h500 + 32'(i * 16));
    add_ray(5, 1);
    wait_idle(200);

    // Two full-size rays back to back at latency 1.
    lat = 1;
    fill_rand(256);
    add_ray(256, 1);
    fill_rand(256);
    add_ray(256, 1);
    wait_idle(2000);

    // Random batches with random latency and back-pressure.
    rand_full = 1;
    for (int b = 0; b < 4; b++) begin
      lat = $urandom_range(1, 5);
      for (int k = 0; k < 10; k++) begin
        int nt;
        case ($urandom_range(0, 9))
          0: nt = 0;
          1: nt = 1;
          2: nt = 256;
          default: nt = $urandom_range(2, 24);
        endcase
        fill_rand(nt);
        add_ray(nt, 1);
      end
      wait_idle(8000);
    end
    rand_full = 0;

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
